// File: rtl/ads1292_pkg.sv
// Shared types and constants for the ADS1292 frame reader.
// Frame layout: status word, CH1, CH2, three bytes each, MSB first.
package ads1292_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SEND,
    WAIT_RX,
    CS_HOLD,
    EMIT,
    ABORT
  } state_e;

  localparam int         FRAME_BYTES = 9;
  localparam int         CNT_W       = 16;
  localparam logic [7:0] DUMMY_BYTE  = 8'h00;
  localparam logic [3:0] STATUS_HDR  = 4'hC;

endpackage

// File: rtl/ads1292_frame_reader_if.sv
// Byte-level link between the frame reader and spi_master,
// plus the ADS1292 chip select.
interface ads1292_frame_reader_if;

  logic       o_CS_L;
  logic [7:0] o_TX_Byte;
  logic       o_TX_DV;
  logic       i_TX_Ready;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;

  modport master (
    output o_CS_L,
    output o_TX_Byte,
    output o_TX_DV,
    input  i_TX_Ready,
    input  i_RX_DV,
    input  i_RX_Byte
  );

  modport slave (
    input  o_CS_L,
    input  o_TX_Byte,
    input  o_TX_DV,
    output i_TX_Ready,
    output i_RX_DV,
    output i_RX_Byte
  );

endinterface

// File: rtl/ads1292_drdy_sync.sv
// Two-flop synchroniser for the asynchronous DRDY pin plus a
// falling-edge pulse; the FSM acts on it three edges after the pin falls.
module ads1292_drdy_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic drdy_l_i,
  output logic fall_o
);

  // [0],[1] synchronise; [2] is the previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], drdy_l_i};
    end
  end

  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ads1292_frame_reader.sv
// ADS1292 continuous-read frame collector driving spi_master.
// Define ADS_FRAME_CHECK_EN to drop frames whose status header is not 0xC.
module ads1292_frame_reader
  import ads1292_pkg::*;
#(
  parameter int unsigned CS_SETUP_CLKS = 4,
  parameter int unsigned CS_HOLD_CLKS  = 100,
  parameter int unsigned TIMEOUT_CLKS  = 1024
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic        i_DRDY_L,
  ads1292_frame_reader_if.master spi,
  output logic        o_Frame_DV,
  output logic [23:0] o_Status,
  output logic [23:0] o_Ch1,
  output logic [23:0] o_Ch2,
  output logic        o_Overrun,
  output logic        o_Timeout,
  output logic        o_Frame_Err,
  output logic        o_Busy
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CLKS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]       LAST_BYTE  = 4'(FRAME_BYTES - 1);
  localparam int               BUF_W      = FRAME_BYTES * 8;

  logic drdy_fall;

  ads1292_drdy_sync u_sync (
    .clk_i    (i_Clk),
    .rst_i    (i_Rst),
    .drdy_l_i (i_DRDY_L),
    .fall_o   (drdy_fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         byte_cnt_q, byte_cnt_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               cs_q, cs_d;
  logic               frame_dv_q, frame_dv_d;
  logic [23:0]        status_q, status_d;
  logic [23:0]        ch1_q, ch1_d;
  logic [23:0]        ch2_q, ch2_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               tx_dv;
`ifdef ADS_FRAME_CHECK_EN
  logic               err_q, err_d;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      cs_q       <= 1'b1;
      frame_dv_q <= 1'b0;
      status_q   <= '0;
      ch1_q      <= '0;
      ch2_q      <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef ADS_FRAME_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      cs_q       <= cs_d;
      frame_dv_q <= frame_dv_d;
      status_q   <= status_d;
      ch1_q      <= ch1_d;
      ch2_q      <= ch2_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
`ifdef ADS_FRAME_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    cs_d       = cs_q;
    frame_dv_d = 1'b0;
    status_d   = status_q;
    ch1_d      = ch1_q;
    ch2_d      = ch2_q;
    timeout_d  = 1'b0;
    tx_dv      = 1'b0;
`ifdef ADS_FRAME_CHECK_EN
    err_d      = 1'b0;
`endif
    // a DRDY edge during a frame is reported and dropped
    overrun_d  = drdy_fall & (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (drdy_fall && i_Enable) begin
          state_d    = CS_SETUP;
          cs_d       = 1'b0;
          cnt_d      = '0;
          byte_cnt_d = '0;
        end
      end
      CS_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = SEND;
      end
      SEND: begin
        if (spi.i_TX_Ready) begin
          tx_dv   = 1'b1;
          state_d = WAIT_RX;
          cnt_d   = '0;
        end
      end
      WAIT_RX: begin
        if (spi.i_RX_DV) begin
          buf_d      = {buf_q[BUF_W-9:0], spi.i_RX_Byte};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = CS_HOLD;
            cnt_d   = '0;
          end else begin
            state_d = SEND;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ABORT;
          cs_d      = 1'b1;
          timeout_d = 1'b1;
        end
      end
      CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_d    = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        state_d = IDLE;
`ifdef ADS_FRAME_CHECK_EN
        if (buf_q[BUF_W-1 -: 4] != STATUS_HDR) begin
          err_d = 1'b1;
        end else begin
          frame_dv_d = 1'b1;
          status_d   = buf_q[71:48];
          ch1_d      = buf_q[47:24];
          ch2_d      = buf_q[23:0];
        end
`else
        frame_dv_d = 1'b1;
        status_d   = buf_q[71:48];
        ch1_d      = buf_q[47:24];
        ch2_d      = buf_q[23:0];
`endif
      end
      ABORT: begin
        state_d    = IDLE;
        byte_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi.o_CS_L    = cs_q;
  assign spi.o_TX_Byte = DUMMY_BYTE;
  assign spi.o_TX_DV   = tx_dv;
  assign o_Frame_DV    = frame_dv_q;
  assign o_Status      = status_q;
  assign o_Ch1         = ch1_q;
  assign o_Ch2         = ch2_q;
  assign o_Overrun     = overrun_q;
  assign o_Timeout     = timeout_q;
  assign o_Busy        = (state_q != IDLE);
`ifdef ADS_FRAME_CHECK_EN
  assign o_Frame_Err   = err_q;
`else
  assign o_Frame_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_ads1292_frame_reader.sv
// Bench for ads1292_frame_reader: byte-level spi_master model plus an
// ADS1292 MISO model; frames are predicted from the byte order rule.
module tb_ads1292_frame_reader;

  localparam int SPI_CLKS = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        drdy_l;
  logic        frame_dv;
  logic [23:0] st_o, ch1_o, ch2_o;
  logic        ovr_o, tmo_o, err_o, busy_o;

  ads1292_frame_reader_if spi();

  ads1292_frame_reader dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Enable    (en),
    .i_DRDY_L    (drdy_l),
    .spi         (spi),
    .o_Frame_DV  (frame_dv),
    .o_Status    (st_o),
    .o_Ch1       (ch1_o),
    .o_Ch2       (ch2_o),
    .o_Overrun   (ovr_o),
    .o_Timeout   (tmo_o),
    .o_Frame_Err (err_o),
    .o_Busy      (busy_o)
  );

  always #5 clk = ~clk;

  // spi_master + ADS1292 model
  logic [7:0] ads_mem [0:8];
  int         mute_after = 99;
  int         ads_idx = 0;
  int         spi_cnt = 0;
  logic       rdy = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  assign spi.i_TX_Ready = rdy;
  assign spi.i_RX_DV    = rx_dv;
  assign spi.i_RX_Byte  = rx_byte;

  always @(posedge clk) begin
    rx_dv <= 1'b0;
    if (spi.o_CS_L) ads_idx <= 0;
    if (spi.o_TX_DV && rdy) begin
      rdy     <= 1'b0;
      spi_cnt <= SPI_CLKS;
    end else if (!rdy) begin
      spi_cnt <= spi_cnt - 1;
      if (spi_cnt == 1) begin
        rdy <= 1'b1;
        if (!spi.o_CS_L) begin
          if (ads_idx < mute_after) begin
            rx_dv   <= 1'b1;
            rx_byte <= ads_mem[ads_idx];
          end
          ads_idx <= ads_idx + 1;
        end else begin
          rx_dv   <= 1'b1;
          rx_byte <= 8'h5A;
        end
      end
    end
  end

  // monitor: event counters and protocol violations
  int          cyc = 0, tx_cnt = 0, frm_cnt = 0, ovr_cnt = 0;
  int          tmo_cnt = 0, err_cnt = 0, cs_fall = 0;
  int          cs_low_cyc = 0, busy_cyc = 0, viol = 0;
  int          last_tx_cyc = 0, tmo_cyc = 0;
  logic        outst = 1'b0, cs_prev = 1'b1;
  logic [23:0] cap_st = '0, cap_c1 = '0, cap_c2 = '0;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    cs_prev <= spi.o_CS_L;
    if (cs_prev && !spi.o_CS_L) cs_fall <= cs_fall + 1;
    if (!spi.o_CS_L) cs_low_cyc <= cs_low_cyc + 1;
    if (busy_o) busy_cyc <= busy_cyc + 1;
    if (spi.o_TX_DV) begin
      tx_cnt      <= tx_cnt + 1;
      last_tx_cyc <= cyc;
      if (!rdy || outst || spi.o_CS_L || spi.o_TX_Byte != 8'h00)
        viol <= viol + 1;
      outst <= 1'b1;
    end else if (rx_dv || tmo_o) begin
      outst <= 1'b0;
    end
    if (frame_dv) begin
      frm_cnt <= frm_cnt + 1;
      cap_st  <= st_o;
      cap_c1  <= ch1_o;
      cap_c2  <= ch2_o;
    end
    if (ovr_o) ovr_cnt <= ovr_cnt + 1;
    if (tmo_o) begin
      tmo_cnt <= tmo_cnt + 1;
      tmo_cyc <= cyc;
    end
    if (err_o) err_cnt <= err_cnt + 1;
  end

  int vectors = 0, miscompares = 0;
  logic [23:0] exp_st = '0, exp_c1 = '0, exp_c2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_sel(input int sel);
    case (sel)
      0:       return tx_cnt;
      1:       return frm_cnt;
      2:       return tmo_cnt;
      default: return busy_o ? 0 : 1;
    endcase
  endfunction

  task automatic wait_ge(input int sel, input int target,
                         input int budget, output bit ok);
    int n = 0;
    while (cnt_sel(sel) < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    ok = (cnt_sel(sel) >= target);
  endtask

  task automatic load(input logic [71:0] f);
    for (int i = 0; i < 9; i++) ads_mem[i] = f[71-8*i -: 8];
  endtask

  // reference: byte k of the frame is word k/3, byte (k%3) from the MSB
  task automatic predict();
    int w [3];
    for (int k = 0; k < 3; k++) w[k] = 0;
    for (int k = 0; k < 9; k++) w[k/3] = w[k/3] * 256 + int'(ads_mem[k]);
    exp_st = 24'(w[0]);
    exp_c1 = 24'(w[1]);
    exp_c2 = 24'(w[2]);
  endtask

  task automatic pulse_drdy();
    @(posedge clk); #1 drdy_l = 1'b0;
    repeat (4) @(posedge clk);
    #1 drdy_l = 1'b1;
  endtask

  task automatic do_frame(input logic [71:0] f, input string tag);
    int tx0, fr0, cf0;
    bit ok;
    tx0 = tx_cnt; fr0 = frm_cnt; cf0 = cs_fall;
    load(f);
    predict();
    pulse_drdy();
    wait_ge(1, fr0 + 1, 3000, ok);
    chk({tag, "_arrived"}, 32'(ok), 1);
    chk({tag, "_status"}, 32'(cap_st), 32'(exp_st));
    chk({tag, "_ch1"}, 32'(cap_c1), 32'(exp_c1));
    chk({tag, "_ch2"}, 32'(cap_c2), 32'(exp_c2));
    repeat (5) @(posedge clk);
    chk({tag, "_tx_pulses"}, 32'(tx_cnt - tx0), 9);
    chk({tag, "_cs_falls"}, 32'(cs_fall - cf0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0, fr0, ov0, tm0, er0, cl0, bz0, d;
    bit ok;
    logic [71:0] f;
    rst = 1'b1; en = 1'b1; drdy_l = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cs_l", 32'(spi.o_CS_L), 1);
    chk("rst_flags", {26'd0, spi.o_TX_DV, frame_dv, ovr_o, tmo_o, err_o, busy_o}, 0);
    chk("rst_data", 32'(st_o | ch1_o | ch2_o), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    do_frame(72'hC00000_123456_FEDCBA, "fixed");
    for (int i = 0; i < 4; i++) begin
      f = {4'hC, 4'($urandom), 32'($urandom), 32'($urandom)};
      do_frame(f, "rand");
      repeat ($urandom_range(1, 20)) @(posedge clk);
    end

    // overrun: second DRDY edge while byte 4 is in flight
    tx0 = tx_cnt; fr0 = frm_cnt; ov0 = ovr_cnt;
    f = {4'hC, 4'($urandom), 32'($urandom), 32'($urandom)};
    load(f);
    predict();
    pulse_drdy();
    wait_ge(0, tx0 + 5, 2000, ok);
    chk("ovr_reached_byte4", 32'(ok), 1);
    pulse_drdy();
    wait_ge(1, fr0 + 1, 3000, ok);
    chk("ovr_frame_arrived", 32'(ok), 1);
    chk("ovr_ch1", 32'(cap_c1), 32'(exp_c1));
    chk("ovr_ch2", 32'(cap_c2), 32'(exp_c2));
    repeat (600) @(posedge clk);
    chk("ovr_pulses", 32'(ovr_cnt - ov0), 1);
    chk("ovr_frames", 32'(frm_cnt - fr0), 1);
    chk("ovr_tx_pulses", 32'(tx_cnt - tx0), 9);

    // timeout: model answers bytes 0..2 only
    tx0 = tx_cnt; fr0 = frm_cnt; tm0 = tmo_cnt;
    mute_after = 3;
    load({4'hC, 4'($urandom), 32'($urandom), 32'($urandom)});
    pulse_drdy();
    wait_ge(2, tm0 + 1, 4000, ok);
    chk("tmo_fired", 32'(ok), 1);
    d = tmo_cyc - last_tx_cyc;
    chk("tmo_latency_ok", 32'(d >= 1020 && d <= 1030), 1);
    repeat (5) @(posedge clk);
    chk("tmo_cs_high", 32'(spi.o_CS_L), 1);
    chk("tmo_tx_pulses", 32'(tx_cnt - tx0), 4);
    chk("tmo_no_frame", 32'(frm_cnt - fr0), 0);
    mute_after = 99;
    repeat (50) @(posedge clk);

    // reset while byte 5 is in flight
    tx0 = tx_cnt; fr0 = frm_cnt;
    load({4'hC, 4'($urandom), 32'($urandom), 32'($urandom)});
    pulse_drdy();
    wait_ge(0, tx0 + 6, 2000, ok);
    chk("rst_reached_byte5", 32'(ok), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cs_l", 32'(spi.o_CS_L), 1);
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_data", 32'(st_o | ch1_o | ch2_o), 0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    chk("midrst_no_frame", 32'(frm_cnt - fr0), 0);
    do_frame({4'hC, 4'($urandom), 32'($urandom), 32'($urandom)}, "postrst");

    // bad status header
    fr0 = frm_cnt; er0 = err_cnt;
    f = {8'h80, 16'($urandom), 48'h0123_4567_89AB};
    load(f);
`ifdef ADS_FRAME_CHECK_EN
    pulse_drdy();
    repeat (20) @(posedge clk);
    wait_ge(3, 1, 3000, ok);
    repeat (5) @(posedge clk);
    chk("hdr_idle", 32'(ok), 1);
    chk("hdr_err_pulses", 32'(err_cnt - er0), 1);
    chk("hdr_no_frame", 32'(frm_cnt - fr0), 0);
    chk("hdr_ch1_kept", 32'(ch1_o), 32'(exp_c1));
`else
    predict();
    pulse_drdy();
    wait_ge(1, fr0 + 1, 3000, ok);
    repeat (5) @(posedge clk);
    chk("hdr_emitted", 32'(ok), 1);
    chk("hdr_status", 32'(cap_st), 32'(exp_st));
    chk("hdr_err_tied", 32'(err_cnt - er0), 0);
`endif

    // disabled: DRDY edge must be ignored
    en = 1'b0;
    cl0 = cs_low_cyc; bz0 = busy_cyc;
    pulse_drdy();
    repeat (50) @(posedge clk);
    chk("dis_cs_activity", 32'(cs_low_cyc - cl0), 0);
    chk("dis_busy", 32'(busy_cyc - bz0), 0);
    chk("dis_status_held", 32'(st_o), 32'(exp_st));
    en = 1'b1;

    chk("tx_protocol_violations", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
